// File: rtl/memory_controller.sv
// memory_controller: 2^DEPTH_LOG2 x 16-bit word memory with fixed-latency,
// in-order read and write return pipelines that never stall.
// Build option: define MEMORY_CONTROLLER_RD_FORWARD_EN to forward same-cycle
// write data to a read of the same storage index. Without it, such a read
// returns the old contents.
module memory_controller #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wr_address,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic [15:0] wr_ret_address,
  output logic        wr_ret_ack,
  input  logic [15:0] rd_address,
  input  logic        rd_en,
  output logic [15:0] rd_ret_data,
  output logic [15:0] rd_ret_address,
  output logic        rd_ret_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // An empty slot is all zeros, so the return outputs read 0 whenever the
  // matching ack is low without any output gating.
  typedef struct packed {
    logic        ack;
    logic [15:0] addr;
    logic [15:0] data;
  } rd_slot_t;

  typedef struct packed {
    logic        ack;
    logic [15:0] addr;
  } wr_slot_t;

  // Contents start at zero and survive reset.
  logic [15:0] storage [DEPTH] = '{default: '0};

  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [15:0]           rd_word;

  rd_slot_t rd_pipe [LATENCY];
  wr_slot_t wr_pipe [LATENCY];

  // Upper address bits alias; they only travel down the return pipes.
  assign wr_idx = wr_address[DEPTH_LOG2-1:0];
  assign rd_idx = rd_address[DEPTH_LOG2-1:0];

  // Read word as seen on the accepting edge (old data unless forwarding).
  always_comb begin
    rd_word = storage[rd_idx];
`ifdef MEMORY_CONTROLLER_RD_FORWARD_EN
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_word = wr_data;
    end
`endif
  end

  // Storage write on the accepting edge; reset blocks acceptance only.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      storage[wr_idx] <= wr_data;
    end
  end

  // Return pipelines: stage 0 loads on accept, last stage drives outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        rd_pipe[i] <= '0;
        wr_pipe[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= rd_en ? {1'b1, rd_address, rd_word} : '0;
      wr_pipe[0] <= wr_en ? {1'b1, wr_address} : '0;
      for (int i = 1; i < LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
        wr_pipe[i] <= wr_pipe[i-1];
      end
    end
  end

  assign rd_ret_ack     = rd_pipe[LATENCY-1].ack;
  assign rd_ret_address = rd_pipe[LATENCY-1].addr;
  assign rd_ret_data    = rd_pipe[LATENCY-1].data;
  assign wr_ret_ack     = wr_pipe[LATENCY-1].ack;
  assign wr_ret_address = wr_pipe[LATENCY-1].addr;

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model (word array + table of
// expected returns indexed by the edge after which they must appear).
module tb_memory_controller;

  localparam int L     = 4;
  localparam int DL2   = 10;
  localparam int DEPTH = 1 << DL2;
  localparam int NEDGE = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wr_address, wr_data, rd_address;
  logic        wr_en, rd_en;
  logic [15:0] wr_ret_address, rd_ret_data, rd_ret_address;
  logic        wr_ret_ack, rd_ret_ack;

  memory_controller #(.DEPTH_LOG2(DL2), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
    .rd_address(rd_address), .rd_en(rd_en),
    .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address),
    .rd_ret_ack(rd_ret_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic [15:0] mem_model [DEPTH];
  logic        exp_rd_v [NEDGE];
  logic [15:0] exp_rd_a [NEDGE];
  logic [15:0] exp_rd_d [NEDGE];
  logic        exp_wr_v [NEDGE];
  logic [15:0] exp_wr_a [NEDGE];

  int rd_ack_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", tag, edge_cnt, got, exp);
    end
  endtask

  // Drive one cycle's inputs, advance the model to the next edge, then
  // compare every output against the model after that edge.
  task automatic cycle(input logic rst, input logic we, input logic [15:0] wa,
                       input logic [15:0] wd, input logic re, input logic [15:0] ra);
    int n;
    int due;
    logic [15:0] rdat;
    reset = rst; wr_en = we; wr_address = wa; wr_data = wd;
    rd_en = re; rd_address = ra;
    n = edge_cnt + 1;
    due = n + L - 1;
    if (rst) begin
      for (int k = n; k <= due; k++) begin
        exp_rd_v[k] = 1'b0;
        exp_wr_v[k] = 1'b0;
      end
    end else begin
      if (re) begin
        rdat = mem_model[ra % DEPTH];
`ifdef MEMORY_CONTROLLER_RD_FORWARD_EN
        if (we && ((wa % DEPTH) == (ra % DEPTH))) rdat = wd;
`endif
        exp_rd_v[due] = 1'b1; exp_rd_a[due] = ra; exp_rd_d[due] = rdat;
      end
      if (we) begin
        mem_model[wa % DEPTH] = wd;
        exp_wr_v[due] = 1'b1; exp_wr_a[due] = wa;
      end
    end
    @(posedge clk);
    edge_cnt = n;
    @(negedge clk);
    if (rd_ret_ack) rd_ack_seen++;
    chk("rd_ack",  32'(rd_ret_ack), 32'(exp_rd_v[n]));
    chk("rd_addr", 32'(rd_ret_address), exp_rd_v[n] ? 32'(exp_rd_a[n]) : 32'd0);
    chk("rd_data", 32'(rd_ret_data),    exp_rd_v[n] ? 32'(exp_rd_d[n]) : 32'd0);
    chk("wr_ack",  32'(wr_ret_ack), 32'(exp_wr_v[n]));
    chk("wr_addr", 32'(wr_ret_address), exp_wr_v[n] ? 32'(exp_wr_a[n]) : 32'd0);
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0;
    for (int i = 0; i < NEDGE; i++) begin
      exp_rd_v[i] = 1'b0; exp_wr_v[i] = 1'b0;
      exp_rd_a[i] = 16'h0; exp_rd_d[i] = 16'h0; exp_wr_a[i] = 16'h0;
    end
    rd_ack_seen = 0;

    // Reset held two cycles with both requests asserted: no acks, zeros after.
    cycle(1'b1, 1'b1, 16'h0011, 16'h2222, 1'b1, 16'h0011);
    cycle(1'b1, 1'b1, 16'h0011, 16'h2222, 1'b1, 16'h0011);
    idle(1);
    chk("reset_rd_ack", 32'(rd_ret_ack), 32'd0);
    chk("reset_wr_ack", 32'(wr_ret_ack), 32'd0);

    // Streaming: address = data incrementing for 250 cycles.
    for (int i = 0; i < 250; i++)
      cycle(1'b0, 1'b1, 16'(i), 16'(i), 1'b1, 16'(i));
    idle(L);

    // Write then read the same word on the next cycle.
    cycle(1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0005);
    idle(L - 2);
    chk("wtr_wr_ack", 32'(wr_ret_ack), 32'd1);
    chk("wtr_wr_addr", 32'(wr_ret_address), 32'h0005);
    idle(1);
    chk("wtr_rd_ack", 32'(rd_ret_ack), 32'd1);
    chk("wtr_rd_data", 32'(rd_ret_data), 32'h1234);
    chk("wtr_rd_addr", 32'(rd_ret_address), 32'h0005);
    idle(2);

    // Aliasing: upper address bits ignored for storage, kept on return.
    cycle(1'b0, 1'b1, 16'h0403, 16'hBEEF, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0003);
    idle(L - 1);
    chk("alias_rd_data", 32'(rd_ret_data), 32'hBEEF);
    chk("alias_rd_addr", 32'(rd_ret_address), 32'h0003);
    idle(2);

    // Mid-flight reset: three reads, then reset one cycle later.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'(16 + i));
    idle(1);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    rd_ack_seen = 0;
    idle(2 * L);
    chk("midflight_rd_acks", 32'(rd_ack_seen), 32'd0);

    // Randomized traffic with a small index pool, aliased upper bits and
    // occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] wa, ra;
      wa = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 63)) << DL2);
      ra = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 63)) << DL2);
      cycle(($urandom_range(0, 39) == 0), 1'($urandom), wa, 16'($urandom), 1'($urandom), ra);
    end
    idle(L + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
